// File: rtl/mips_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : mips_mem_pkg                                               |
// | Description : Shared types and defaults for the data-memory responder:   |
// |               32-bit word type, responder FSM state encoding, default    |
// |               memory depth and default response latency.                 |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package mips_mem_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int unsigned DEPTH_DEFAULT       = 1024;
   localparam int unsigned WAIT_CYCLES_DEFAULT = 2;

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : data_mem_responder_if                                      |
// | Description : Request/response bundle between the processor memory      |
// |               stage (master) and the data-memory responder (slave).      |
// |   req_valid/req_ready  request handshake                                 |
// |   req_we/addr/wdata    store flag, word address, store data              |
// |   rsp_valid/rsp_ready  response handshake                                |
// |   rsp_rdata/rsp_err    load data (0 for stores), out-of-range flag       |
// |   busy                 request in flight (pipeline stall)                |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
interface data_mem_responder_if;
   import mips_mem_pkg::*;

   logic  req_valid;
   logic  req_ready;
   logic  req_we;
   word_t req_addr;
   word_t req_wdata;
   logic  rsp_valid;
   logic  rsp_ready;
   word_t rsp_rdata;
   logic  rsp_err;
   logic  busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );

endinterface
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_array                                                  |
// | Description : Synchronous single-port RAM, DEPTH x 32. One access per    |
// |               enabled edge: write when we_i, otherwise registered read.  |
// |   clk      clock                                                         |
// |   en_i     access enable                                                 |
// |   we_i     1 = write, 0 = read                                           |
// |   addr_i   word index                                                    |
// |   wdata_i  write data                                                    |
// |   rdata_o  read data, holds until the next enabled read                  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module mem_array
   import mips_mem_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT,
   parameter int unsigned AW    = $clog2(DEPTH)
)(
   input  logic          clk,
   input  logic          en_i,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  word_t         wdata_i,
   output word_t         rdata_o
);

   // Deliberately has no reset: contents survive a responder reset.
   word_t DataMem [DEPTH];
   word_t rdata_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            DataMem[addr_i] <= wdata_i;
         end else begin
            rdata_q <= DataMem[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : data_mem_responder                                         |
// | Description : Data-memory responder for the processor memory stage.      |
// |               Accepts one request in IDLE, waits WAIT_CYCLES, performs   |
// |               the memory access on the edge entering RESP, then holds    |
// |               the response until it is accepted.                         |
// |   clk      clock, rising edge                                            |
// |   reset    asynchronous, active-low                                      |
// |   mem_if   request/response bundle (slave side)                          |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module data_mem_responder
   import mips_mem_pkg::*;
#(
   parameter int unsigned DEPTH       = DEPTH_DEFAULT,
   parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
)(
   input  logic                 clk,
   input  logic                 reset,
   data_mem_responder_if.slave  mem_if
);

   localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam word_t       DEPTH_W   = word_t'(DEPTH);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

   state_t     state_q, state_d;
   logic [3:0] cnt_q,   cnt_d;
   logic       we_q,    we_d;
   word_t      addr_q,  addr_d;
   word_t      wdata_q, wdata_d;

   logic       transfer;
   logic       enter_resp;
   logic       op_we;
   word_t      op_addr;
   word_t      op_wdata;
   logic       op_in_range;
   logic       resp_in_range;
   word_t      mem_rdata;

   assign transfer = mem_if.req_valid && (state_q == ST_IDLE);

   // With zero wait the access happens on the transfer edge itself, before
   // the request has been captured, so the memory is fed from the bus then.
   assign enter_resp = (WAIT_CYCLES == 0) ? transfer
                                          : ((state_q == ST_WAIT) && (cnt_q == 4'd1));

   assign op_we    = (state_q == ST_IDLE) ? mem_if.req_we    : we_q;
   assign op_addr  = (state_q == ST_IDLE) ? mem_if.req_addr  : addr_q;
   assign op_wdata = (state_q == ST_IDLE) ? mem_if.req_wdata : wdata_q;

   // Full 32-bit compare so high address bits never alias into the array.
   assign op_in_range   = (op_addr < DEPTH_W);
   assign resp_in_range = (addr_q  < DEPTH_W);

   mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .en_i    (enter_resp && op_in_range),
      .we_i    (op_we),
      .addr_i  (op_addr[AW-1:0]),
      .wdata_i (op_wdata),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (transfer) begin
               we_d    = mem_if.req_we;
               addr_d  = mem_if.req_addr;
               wdata_d = mem_if.req_wdata;
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (enter_resp) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (mem_if.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   assign mem_if.req_ready = (state_q == ST_IDLE);
   assign mem_if.rsp_valid = (state_q == ST_RESP);
   assign mem_if.busy      = (state_q != ST_IDLE);
   assign mem_if.rsp_err   = (state_q == ST_RESP) && !resp_in_range;
   // Read register is not reset; gating here gives zero data on reset,
   // for stores and for out-of-range requests.
   assign mem_if.rsp_rdata = ((state_q == ST_RESP) && !we_q && resp_in_range) ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_data_mem_responder                                      |
// | Description : Self-checking bench. Instance A: DEPTH 1024, 2 wait        |
// |               cycles, table-driven vectors plus reset corner case.       |
// |               Instance B: DEPTH 16, 0 wait cycles, back-to-back and      |
// |               random traffic against an array memory model.              |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_data_mem_responder;
   import mips_mem_pkg::*;

   localparam int DEPTH_A = 1024;
   localparam int WAIT_A  = 2;
   localparam int DEPTH_B = 16;
   localparam int WAIT_B  = 0;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   data_mem_responder_if if_a ();
   data_mem_responder_if if_b ();

   data_mem_responder #(.DEPTH(DEPTH_A), .WAIT_CYCLES(WAIT_A)) dut_a (
      .clk(clk), .reset(reset), .mem_if(if_a.slave));
   data_mem_responder #(.DEPTH(DEPTH_B), .WAIT_CYCLES(WAIT_B)) dut_b (
      .clk(clk), .reset(reset), .mem_if(if_b.slave));

   logic  d_valid [2];
   logic  d_we    [2];
   word_t d_addr  [2];
   word_t d_wdata [2];
   logic  d_rready[2];
   logic  s_req_ready[2];
   logic  s_rsp_valid[2];
   word_t s_rdata    [2];
   logic  s_err      [2];
   logic  s_busy     [2];

   assign if_a.req_valid = d_valid[0];
   assign if_a.req_we    = d_we[0];
   assign if_a.req_addr  = d_addr[0];
   assign if_a.req_wdata = d_wdata[0];
   assign if_a.rsp_ready = d_rready[0];
   assign if_b.req_valid = d_valid[1];
   assign if_b.req_we    = d_we[1];
   assign if_b.req_addr  = d_addr[1];
   assign if_b.req_wdata = d_wdata[1];
   assign if_b.rsp_ready = d_rready[1];
   assign s_req_ready[0] = if_a.req_ready;
   assign s_rsp_valid[0] = if_a.rsp_valid;
   assign s_rdata[0]     = if_a.rsp_rdata;
   assign s_err[0]       = if_a.rsp_err;
   assign s_busy[0]      = if_a.busy;
   assign s_req_ready[1] = if_b.req_ready;
   assign s_rsp_valid[1] = if_b.rsp_valid;
   assign s_rdata[1]     = if_b.rsp_rdata;
   assign s_err[1]       = if_b.rsp_err;
   assign s_busy[1]      = if_b.busy;

   int last_xfer[2];

   typedef struct {
      logic  we;
      word_t addr;
      word_t wdata;
      int    hold;
      word_t exp_rdata;
      logic  exp_err;
   } vec_t;

   task automatic chk(input string name, input word_t act, input word_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int exp_lat(input int d);
      return (d == 0) ? WAIT_A + 1 : WAIT_B + 1;
   endfunction

   task automatic chk_reset(input int d);
      chk("reset_req_ready", 32'(s_req_ready[d]), 32'd1);
      chk("reset_rsp_valid", 32'(s_rsp_valid[d]), 32'd0);
      chk("reset_rsp_rdata", s_rdata[d], 32'd0);
      chk("reset_rsp_err",   32'(s_err[d]),       32'd0);
      chk("reset_busy",      32'(s_busy[d]),      32'd0);
   endtask

   // One full transaction; called #1 after a rising edge, returns likewise.
   task automatic txn(input int d, input logic we, input word_t addr, input word_t wdata,
                      input int hold, input word_t exp_rdata, input logic exp_err);
      int guard;
      int lat;
      guard = 0;
      while (!s_req_ready[d] && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("req_ready_idle", 32'(s_req_ready[d]), 32'd1);
      d_valid[d] = 1'b1;
      d_we[d]    = we;
      d_addr[d]  = addr;
      d_wdata[d] = wdata;
      @(posedge clk); #1;
      last_xfer[d] = cyc;
      d_valid[d] = 1'b0;
      d_we[d]    = 1'b0;
      d_addr[d]  = $urandom();
      d_wdata[d] = $urandom();
      lat = 1;
      while (!s_rsp_valid[d] && lat < 40) begin
         chk("wait_busy",      32'(s_busy[d]),      32'd1);
         chk("wait_req_ready", 32'(s_req_ready[d]), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), 32'(exp_lat(d)));
      if (!s_rsp_valid[d]) return;
      // A competing request held during RESP must never be taken.
      d_valid[d] = 1'b1;
      for (int i = 0; i <= hold; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         chk("rsp_valid",      32'(s_rsp_valid[d]), 32'd1);
         chk("rsp_rdata",      s_rdata[d],          exp_rdata);
         chk("rsp_err",        32'(s_err[d]),       32'(exp_err));
         chk("resp_req_ready", 32'(s_req_ready[d]), 32'd0);
         chk("resp_busy",      32'(s_busy[d]),      32'd1);
      end
      d_rready[d] = 1'b1;
      @(posedge clk); #1;
      d_rready[d] = 1'b0;
      d_valid[d]  = 1'b0;
      chk("post_req_ready", 32'(s_req_ready[d]), 32'd1);
      chk("post_rsp_valid", 32'(s_rsp_valid[d]), 32'd0);
      chk("post_busy",      32'(s_busy[d]),      32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t  vt[14];
      word_t model[DEPTH_B];
      word_t mem0_before;
      int    prev;

      for (int d = 0; d < 2; d++) begin
         d_valid[d] = 1'b0; d_we[d] = 1'b0; d_addr[d] = '0;
         d_wdata[d] = '0;   d_rready[d] = 1'b0; last_xfer[d] = 0;
      end
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset(0);
      chk_reset(1);
      reset = 1'b1;
      @(posedge clk); #1;

      // ---------------- instance A: table-driven vectors ----------------
      vt[0]  = '{1'b1, 32'd2,          32'd8,          0, 32'd0,          1'b0};
      vt[1]  = '{1'b0, 32'd2,          32'd0,          0, 32'd8,          1'b0};
      vt[2]  = '{1'b1, 32'd7,          32'd21,         1, 32'd0,          1'b0};
      vt[3]  = '{1'b0, 32'd7,          32'd0,          0, 32'd21,         1'b0};
      vt[4]  = '{1'b1, 32'd4,          32'd13,         0, 32'd0,          1'b0};
      vt[5]  = '{1'b0, 32'd4,          32'd0,          5, 32'd13,         1'b0};
      vt[6]  = '{1'b1, 32'd1024,       32'hCAFEF00D,   0, 32'd0,          1'b1};
      vt[7]  = '{1'b0, 32'd1024,       32'd0,          2, 32'd0,          1'b1};
      vt[8]  = '{1'b0, 32'hFFFFFFFF,   32'd0,          0, 32'd0,          1'b1};
      vt[9]  = '{1'b1, 32'h00000402,   32'h12345678,   0, 32'd0,          1'b1};
      vt[10] = '{1'b0, 32'h00000402,   32'd0,          0, 32'd0,          1'b1};
      vt[11] = '{1'b1, 32'd1023,       32'h00005555,   0, 32'd0,          1'b0};
      vt[12] = '{1'b0, 32'd1023,       32'd0,          0, 32'h00005555,   1'b0};
      vt[13] = '{1'b1, 32'd5,          32'h00000011,   0, 32'd0,          1'b0};

      mem0_before = dut_a.u_mem.DataMem[0];
      for (int i = 0; i < 14; i++) begin
         prev = last_xfer[0];
         txn(0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].hold, vt[i].exp_rdata, vt[i].exp_err);
         if (i > 0)
            chk("throughput_gap_a", 32'(last_xfer[0] - prev), 32'(WAIT_A + 2 + vt[i-1].hold));
      end
      chk("datamem7",    dut_a.u_mem.DataMem[7],    32'd21);
      chk("datamem2",    dut_a.u_mem.DataMem[2],    32'd8);
      chk("datamem0",    dut_a.u_mem.DataMem[0],    mem0_before);
      chk("datamem1023", dut_a.u_mem.DataMem[1023], 32'h00005555);

      // ---------------- instance A: reset during WAIT of a store --------
      d_valid[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'd5; d_wdata[0] = 32'hDEADBEEF;
      @(posedge clk); #1;
      d_valid[0] = 1'b0; d_we[0] = 1'b0;
      chk("store_in_wait_busy", 32'(s_busy[0]), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk_reset(0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      chk_reset(0);
      chk("datamem5_after_reset", dut_a.u_mem.DataMem[5], 32'h00000011);
      @(posedge clk); #1;
      txn(0, 1'b0, 32'd5, 32'd0, 0, 32'h00000011, 1'b0);

      // ---------------- instance B: zero wait, back-to-back loads ------
      for (int a = 0; a < DEPTH_B; a++) begin
         model[a] = $urandom();
         txn(1, 1'b1, 32'(a), model[a], 0, 32'd0, 1'b0);
      end
      txn(1, 1'b0, 32'd3, 32'd0, 0, model[3], 1'b0);
      prev = last_xfer[1];
      txn(1, 1'b0, 32'd9, 32'd0, 0, model[9], 1'b0);
      chk("throughput_gap_b", 32'(last_xfer[1] - prev), 32'(WAIT_B + 2));

      // ---------------- instance B: random traffic vs model -------------
      for (int n = 0; n < 80; n++) begin
         logic  we;
         word_t addr;
         word_t wdata;
         int    r;
         logic  in_rng;
         we    = 1'($urandom_range(0, 1));
         r     = int'($urandom_range(0, 9));
         wdata = $urandom();
         if (r < 7)       addr = 32'($urandom_range(0, DEPTH_B - 1));
         else if (r == 7) addr = 32'($urandom_range(DEPTH_B, 40));
         else             addr = $urandom() | 32'h00000010;
         in_rng = (addr < 32'(DEPTH_B));
         txn(1, we, addr, wdata, int'($urandom_range(0, 2)),
             (!we && in_rng) ? model[addr[3:0]] : 32'd0, !in_rng);
         if (we && in_rng) model[addr[3:0]] = wdata;
      end
      for (int a = 0; a < DEPTH_B; a++)
         chk("model_vs_datamem_b", dut_b.u_mem.DataMem[a], model[a]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 1024, number of 32-bit data words (power of two).
REQ-002 Parameter WAIT_CYCLES, default 2, added latency between request accept and response (0..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  processor memory-stage request present.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store (SW), 0 = load (LW).
REQ-008 req_addr  input  32  word address (effective address, word-indexed as DataMem[] is indexed).
REQ-009 req_wdata  input  32  store data.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  processor accepts the response.
REQ-012 rsp_rdata  output  32  load data; 0 for stores.
REQ-013 rsp_err  output  1  address was out of range (req_addr >= DEPTH).
REQ-014 busy  output  1  a request is in flight; drives the pipeline stall.

Function
REQ-015 A request SHALL transfer only on a cycle where req_valid and req_ready are both 1.
REQ-016 FSM states SHALL be IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: on transfer, capture we/addr/wdata; go to WAIT with counter = WAIT_CYCLES, or directly to RESP when WAIT_CYCLES = 0.
REQ-018 WAIT: decrement the counter each cycle; on the cycle the counter reaches 1, move to RESP next edge, so rsp_valid first asserts exactly WAIT_CYCLES+1 cycles after the transfer edge.
REQ-019 Stores SHALL write memory on the edge that enters RESP; loads SHALL sample memory on the same edge into a response register.
REQ-020 RESP: hold rsp_valid, rsp_rdata, rsp_err stable until rsp_ready = 1; on that edge return to IDLE.
REQ-021 No request SHALL be accepted in the RESP cycle it is released in; back-to-back throughput SHALL be one request per WAIT_CYCLES+2 cycles.
REQ-022 Out-of-range request: no memory write, rsp_rdata = 0, rsp_err = 1; timing SHALL be identical to an in-range request.
REQ-023 Address SHALL be range-checked on all 32 bits and never wrap modulo DEPTH.
REQ-024 A load after a store to the same address SHALL return the stored value (no stale read).
REQ-025 busy SHALL equal 1 in WAIT and RESP, and 0 in IDLE.
REQ-026 Memory contents SHALL be directly writable/readable by the bench hierarchically through an array named DataMem.

Reset
REQ-027 reset low SHALL immediately force IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0, counter = 0.
REQ-028 Reset SHALL NOT clear DataMem; a store in flight when reset asserts SHALL be discarded if RESP has not been entered.
REQ-029 Outputs SHALL leave reset values only on the first clk edge after reset deasserts.

Structure
REQ-030 Shared package mips_mem_pkg SHALL hold the FSM state enum, the 32-bit word typedef, and the WAIT_CYCLES default.
REQ-031 One sub-module, mem_array (synchronous single-port RAM, DEPTH x 32), is natural; FSM and handshake logic stay in data_mem_responder.

Verification
REQ-032 DataMem[2] = 8; load addr 2, WAIT_CYCLES = 2, rsp_ready = 1 -> rsp_valid asserts 3 cycles after the transfer, rsp_rdata = 8, rsp_err = 0.
REQ-033 Store 21 to addr 7, then load addr 7 -> DataMem[7] = 21 and the load returns 21.
REQ-034 Load addr 4 (DataMem[4] = 13) with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata = 13 stay stable; req_ready = 0 throughout; IDLE one cycle after rsp_ready = 1.
REQ-035 Store to addr 1024 with DEPTH = 1024 -> rsp_err = 1, rsp_rdata = 0, DataMem[0] unchanged.
REQ-036 Assert reset in WAIT of a store of 0xDEADBEEF to addr 5 -> outputs reach reset values with no clock edge, and DataMem[5] is unchanged.
REQ-037 WAIT_CYCLES = 0, two back-to-back loads -> each rsp_valid 1 cycle after its transfer; second transfer no earlier than 2 cycles after the first.
